// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit.
//   - funct3 encodings for load/store size and sign
//   - FSM state encoding
//   - default wait budget before a data-memory access is declared faulty
//   - latched request record and small decode helpers
package mem_pkg;

    localparam int MAX_WAIT_DEFAULT = 15;

    // funct3 load/store encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Everything the bus and the load formatter need, latched at issue so the
    // bus stays stable while the memory is slow.
    typedef struct packed {
        logic        is_load;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [2:0]  f3;
        logic [1:0]  lo;
    } req_t;

    // Unsigned load variants exist only for loads.
    function automatic logic funct3_legal(input logic [2:0] f3, input logic is_store);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !is_store;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return (lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << {lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus.
//   master (memory access unit): req, we, addr (word aligned), wdata, be
//   slave  (data memory):        ack, rdata (valid while ack=1)
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, be, input ack, rdata);
    modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// load_formatter: selects the addressed byte/halfword from a 32-bit read word
// and sign- or zero-extends it according to funct3. Purely combinational.
//   rdata_i   : raw word from data memory
//   funct3_i  : load size/sign
//   addr_lo_i : byte address bits [1:0]
//   data_o    : register-ready load result
module load_formatter
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] data_o
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = rdata_i[8*gi +: 8];
    end

    assign byte_sel = lane[addr_lo_i];
    assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        data_o = rdata_i;
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'h0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'h0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage controller between the EX/MEM register and a
// data memory with a variable-latency ack handshake.
//   clk, reset            : clock, synchronous active-high reset
//   ex_*                  : EX/MEM slot contents
//   dmem (master)         : data-memory bus
//   mem_data_mem/addr/we  : MEM/WB register inputs
//   stall                 : freezes IF..EX/MEM while an access is outstanding
//   mem_fault             : one-cycle fault pulse (illegal access or timeout)
//
// Non-memory ops pass straight through with no latency. A legal memory op
// raises dmem.req in the cycle it is presented (that cycle is the first request
// cycle, so an ack there completes the access), then holds the latched request
// in REQ until ack or until MAX_WAIT REQ cycles pass without one. RESP presents
// the result for one unstalled cycle.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ex_valid,
    input  logic [31:0]        ex_alu_result,
    input  logic [31:0]        ex_store_data,
    input  logic [4:0]         ex_rd_addr,
    input  logic               ex_rd_we,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    input  logic [2:0]         ex_funct3,
    mem_access_unit_if.master  dmem,
    output logic [31:0]        mem_data_mem,
    output logic [4:0]         mem_addr_mem,
    output logic               mem_we_mem,
    output logic               stall,
    output logic               mem_fault
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    state_t      state_q,   state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] result_q,  result_d;
    logic        timeout_q, timeout_d;
    req_t        req_q,     req_d;

    req_t        issue;
    req_t        cur;
    logic        is_mem;
    logic        op_fault;
    logic        op_issue;
    logic        drive_bus;
    logic [31:0] fmt_data;

    // Decode of the instruction currently in EX/MEM.
    assign is_mem   = ex_valid & (ex_mem_read | ex_mem_write);
    assign op_fault = is_mem & ((ex_mem_read & ex_mem_write)
                              | !funct3_legal(ex_funct3, ex_mem_write)
                              | misaligned(ex_funct3, ex_alu_result[1:0]));
    assign op_issue = is_mem & !op_fault;

    always_comb begin
        issue         = '0;
        issue.is_load = ex_mem_read;
        issue.we      = ex_mem_write;
        issue.addr    = {ex_alu_result[31:2], 2'b00};
        issue.be      = lane_mask(ex_funct3, ex_alu_result[1:0]);
        issue.f3      = ex_funct3;
        issue.lo      = ex_alu_result[1:0];
        if (ex_mem_write) begin
            case (ex_funct3[1:0])
                2'b00:   issue.wdata = {4{ex_store_data[7:0]}};
                2'b01:   issue.wdata = {2{ex_store_data[15:0]}};
                default: issue.wdata = ex_store_data;
            endcase
        end
    end

    // In REQ the latched copy drives the bus so it cannot move before ack.
    assign cur = (state_q == ST_REQ) ? req_q : issue;

    load_formatter u_load_formatter (
        .rdata_i   (dmem.rdata),
        .funct3_i  (cur.f3),
        .addr_lo_i (cur.lo),
        .data_o    (fmt_data)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        timeout_d    = timeout_q;
        req_d        = req_q;
        drive_bus    = 1'b0;
        mem_data_mem = ex_alu_result;
        mem_addr_mem = ex_rd_addr;
        mem_we_mem   = 1'b0;
        stall        = 1'b0;
        mem_fault    = 1'b0;
        dmem.req     = 1'b0;
        dmem.we      = 1'b0;
        dmem.addr    = '0;
        dmem.wdata   = '0;
        dmem.be      = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (op_fault) begin
                    // Illegal access never reaches memory and does not stall.
                    mem_fault = 1'b1;
                end else if (op_issue) begin
                    drive_bus = 1'b1;
                    stall     = 1'b1;
                    req_d     = issue;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    if (dmem.ack) begin
                        result_d = issue.is_load ? fmt_data : 32'h0;
                        state_d  = ST_RESP;
                    end else begin
                        state_d  = ST_REQ;
                    end
                end else begin
                    mem_we_mem = ex_valid & ex_rd_we;
                end
            end

            ST_REQ: begin
                drive_bus = 1'b1;
                stall     = 1'b1;
                if (dmem.ack) begin
                    result_d = req_q.is_load ? fmt_data : 32'h0;
                    state_d  = ST_RESP;
                end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    // This is the MAX_WAIT-th REQ cycle without ack.
                    timeout_d = 1'b1;
                    result_d  = 32'h0;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RESP: begin
                mem_data_mem = result_q;
                mem_we_mem   = req_q.is_load & ex_rd_we & !timeout_q;
                mem_fault    = timeout_q;
                state_d      = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        if (drive_bus) begin
            dmem.req   = 1'b1;
            dmem.we    = cur.we;
            dmem.addr  = cur.addr;
            dmem.wdata = cur.wdata;
            dmem.be    = cur.be;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
            req_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
            req_q     <= req_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit plus hand sequences for
// multi-cycle behaviour (slow ack, timeout, reset during an access).
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_we;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] mem_data_mem;
    logic [4:0]  mem_addr_mem;
    logic        mem_we_mem;
    logic        stall;
    logic        mem_fault;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_unit_if dmem_bus ();

    mem_access_unit #(.MAX_WAIT(15)) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_rd_addr    (ex_rd_addr),
        .ex_rd_we      (ex_rd_we),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_funct3     (ex_funct3),
        .dmem          (dmem_bus),
        .mem_data_mem  (mem_data_mem),
        .mem_addr_mem  (mem_addr_mem),
        .mem_we_mem    (mem_we_mem),
        .stall         (stall),
        .mem_fault     (mem_fault)
    );

    typedef struct {
        logic        valid;
        logic        rd_en;
        logic        wr_en;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        rd_we;
        logic        e_req;
        logic        e_stall;
        logic        e_fault;
        logic        e_mwe;
        logic [31:0] e_data;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] r_data;
        logic        r_we;
    } vec_t;

    vec_t vecs [17];

    task automatic check_b(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd_en, input logic wr_en,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [4:0] rd, input logic rwe);
        ex_valid      = v;
        ex_mem_read   = rd_en;
        ex_mem_write  = wr_en;
        ex_funct3     = f3;
        ex_alu_result = alu;
        ex_store_data = sd;
        ex_rd_addr    = rd;
        ex_rd_we      = rwe;
    endtask

    // Runs an already-driven memory op, raising ack in cycle ack_at (0 = the
    // issuing cycle, -1 = never). Checks the bus every stalled cycle and
    // returns at mid-cycle of the first unstalled cycle.
    task automatic run_op(input int ack_at, input logic [31:0] rdata,
                          input logic [31:0] e_addr, input logic e_we,
                          input logic chk_store, input logic [3:0] e_be,
                          input logic [31:0] e_wdata, input string tag,
                          output int n_stall);
        n_stall = 0;
        for (int c = 0; c < 40; c++) begin
            dmem_bus.ack   = (c == ack_at);
            dmem_bus.rdata = (c == ack_at) ? rdata : 32'h0;
            @(negedge clk);
            if (!stall) break;
            n_stall++;
            check_b({tag, "_req"}, dmem_bus.req, 1'b1);
            check_w({tag, "_addr"}, dmem_bus.addr, e_addr);
            check_b({tag, "_we"}, dmem_bus.we, e_we);
            check_b({tag, "_wb_blocked"}, mem_we_mem, 1'b0);
            if (chk_store) begin
                check_w({tag, "_be"}, 32'(dmem_bus.be), 32'(e_be));
                check_w({tag, "_wdata"}, dmem_bus.wdata, e_wdata);
            end
            tick();
        end
        dmem_bus.ack   = 1'b0;
        dmem_bus.rdata = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ns;
        vec_t v;

        //            val  rd   wr   f3      alu           sd            rdata         rd     rwe   req  stl  flt  mwe  e_data        e_addr       be     e_wdata       r_data        r_we
        vecs[0]  = '{1'b1,1'b0,1'b0,3'b000,32'h0000_1234,32'h0,        32'h0,        5'd5, 1'b1, 1'b0,1'b0,1'b0,1'b1,32'h0000_1234,32'h0,       4'h0, 32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b0,1'b0,1'b0,3'b000,32'h0000_DEAD,32'h0,        32'h0,        5'd7, 1'b1, 1'b0,1'b0,1'b0,1'b0,32'h0000_DEAD,32'h0,       4'h0, 32'h0,        32'h0,        1'b0};
        vecs[2]  = '{1'b1,1'b0,1'b0,3'b000,32'hFFFF_0000,32'h0,        32'h0,        5'd31,1'b0, 1'b0,1'b0,1'b0,1'b0,32'hFFFF_0000,32'h0,       4'h0, 32'h0,        32'h0,        1'b0};
        vecs[3]  = '{1'b1,1'b1,1'b0,3'b010,32'h0000_0101,32'h0,        32'h0,        5'd3, 1'b1, 1'b0,1'b0,1'b1,1'b0,32'h0,        32'h0,       4'h0, 32'h0,        32'h0,        1'b0};
        vecs[4]  = '{1'b1,1'b1,1'b0,3'b001,32'h0000_0203,32'h0,        32'h0,        5'd3, 1'b1, 1'b0,1'b0,1'b1,1'b0,32'h0,        32'h0,       4'h0, 32'h0,        32'h0,        1'b0};
        vecs[5]  = '{1'b1,1'b1,1'b0,3'b101,32'h0000_0201,32'h0,        32'h0,        5'd3, 1'b1, 1'b0,1'b0,1'b1,1'b0,32'h0,        32'h0,       4'h0, 32'h0,        32'h0,        1'b0};
        vecs[6]  = '{1'b1,1'b1,1'b1,3'b010,32'h0000_0100,32'h0,        32'h0,        5'd3, 1'b1, 1'b0,1'b0,1'b1,1'b0,32'h0,        32'h0,       4'h0, 32'h0,        32'h0,        1'b0};
        vecs[7]  = '{1'b1,1'b1,1'b0,3'b011,32'h0000_0100,32'h0,        32'h0,        5'd3, 1'b1, 1'b0,1'b0,1'b1,1'b0,32'h0,        32'h0,       4'h0, 32'h0,        32'h0,        1'b0};
        vecs[8]  = '{1'b1,1'b0,1'b1,3'b100,32'h0000_0100,32'h1,        32'h0,        5'd0, 1'b0, 1'b0,1'b0,1'b1,1'b0,32'h0,        32'h0,       4'h0, 32'h0,        32'h0,        1'b0};
        vecs[9]  = '{1'b1,1'b1,1'b0,3'b010,32'h0000_0200,32'h0,        32'h1122_3344,5'd10,1'b1, 1'b1,1'b1,1'b0,1'b0,32'h0,        32'h200,     4'hF, 32'h0,        32'h1122_3344,1'b1};
        vecs[10] = '{1'b1,1'b1,1'b0,3'b100,32'h0000_0102,32'h0,        32'h80FF_FF7F,5'd11,1'b1, 1'b1,1'b1,1'b0,1'b0,32'h0,        32'h100,     4'h0, 32'h0,        32'h0000_00FF,1'b1};
        vecs[11] = '{1'b1,1'b1,1'b0,3'b001,32'h0000_0106,32'h0,        32'h8001_7FFF,5'd12,1'b1, 1'b1,1'b1,1'b0,1'b0,32'h0,        32'h104,     4'h0, 32'h0,        32'hFFFF_8001,1'b1};
        vecs[12] = '{1'b1,1'b1,1'b0,3'b101,32'h0000_0104,32'h0,        32'h8001_9ABC,5'd13,1'b1, 1'b1,1'b1,1'b0,1'b0,32'h0,        32'h104,     4'h0, 32'h0,        32'h0000_9ABC,1'b1};
        vecs[13] = '{1'b1,1'b1,1'b0,3'b000,32'h0000_0101,32'h0,        32'h0000_7F00,5'd14,1'b1, 1'b1,1'b1,1'b0,1'b0,32'h0,        32'h100,     4'h0, 32'h0,        32'h0000_007F,1'b1};
        vecs[14] = '{1'b1,1'b0,1'b1,3'b000,32'h0000_0043,32'h1234_56A5,32'h0,        5'd4, 1'b1, 1'b1,1'b1,1'b0,1'b0,32'h0,        32'h040,     4'h8, 32'hA5A5_A5A5,32'h0,        1'b0};
        vecs[15] = '{1'b1,1'b0,1'b1,3'b010,32'h0000_0080,32'hCAFE_F00D,32'h0,        5'd0, 1'b0, 1'b1,1'b1,1'b0,1'b0,32'h0,        32'h080,     4'hF, 32'hCAFE_F00D,32'h0,        1'b0};
        vecs[16] = '{1'b1,1'b1,1'b0,3'b000,32'h0000_0100,32'h0,        32'h0000_00FE,5'd15,1'b0, 1'b1,1'b1,1'b0,1'b0,32'h0,        32'h100,     4'h0, 32'h0,        32'hFFFF_FFFE,1'b0};

        // Reset and idle state
        reset          = 1'b1;
        dmem_bus.ack   = 1'b0;
        dmem_bus.rdata = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_b("rst_req", dmem_bus.req, 1'b0);
        check_b("rst_we", dmem_bus.we, 1'b0);
        check_w("rst_be", 32'(dmem_bus.be), 32'h0);
        check_b("rst_fault", mem_fault, 1'b0);
        check_b("rst_stall", stall, 1'b0);
        check_b("rst_mwe", mem_we_mem, 1'b0);
        $display("txn reset: idle outputs checked");

        // Table: pass-through, IDLE faults, and accesses acked in their first request cycle
        for (int i = 0; i < 17; i++) begin
            v = vecs[i];
            tick();
            drive(v.valid, v.rd_en, v.wr_en, v.f3, v.alu, v.sd, v.rd, v.rd_we);
            dmem_bus.ack   = 1'b1;
            dmem_bus.rdata = v.rdata;
            @(negedge clk);
            check_b($sformatf("v%0d_req", i), dmem_bus.req, v.e_req);
            check_b($sformatf("v%0d_stall", i), stall, v.e_stall);
            check_b($sformatf("v%0d_fault", i), mem_fault, v.e_fault);
            check_b($sformatf("v%0d_mwe", i), mem_we_mem, v.e_mwe);
            if (!v.e_req && !v.e_fault) begin
                check_w($sformatf("v%0d_data", i), mem_data_mem, v.e_data);
                check_w($sformatf("v%0d_rd", i), 32'(mem_addr_mem), 32'(v.rd));
            end
            if (v.e_req) begin
                check_w($sformatf("v%0d_dmem_addr", i), dmem_bus.addr, v.e_addr);
                check_b($sformatf("v%0d_dmem_we", i), dmem_bus.we, v.wr_en);
                if (v.wr_en) begin
                    check_w($sformatf("v%0d_be", i), 32'(dmem_bus.be), 32'(v.e_be));
                    check_w($sformatf("v%0d_wdata", i), dmem_bus.wdata, v.e_wdata);
                end
                tick();
                dmem_bus.ack   = 1'b0;
                dmem_bus.rdata = 32'h0;
                @(negedge clk);
                check_b($sformatf("v%0d_resp_stall", i), stall, 1'b0);
                check_b($sformatf("v%0d_resp_req", i), dmem_bus.req, 1'b0);
                check_b($sformatf("v%0d_resp_fault", i), mem_fault, 1'b0);
                check_b($sformatf("v%0d_resp_mwe", i), mem_we_mem, v.r_we);
                check_w($sformatf("v%0d_resp_rd", i), 32'(mem_addr_mem), 32'(v.rd));
                if (!v.wr_en)
                    check_w($sformatf("v%0d_resp_data", i), mem_data_mem, v.r_data);
            end
            dmem_bus.ack = 1'b0;
            $display("txn vec %0d: valid=%0b rd=%0b wr=%0b f3=%03b addr=0x%08h", i,
                     v.valid, v.rd_en, v.wr_en, v.f3, v.alu);
        end

        // LB from 0x103, ack in the third stalled cycle
        tick();
        drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd9, 1'b1);
        run_op(2, 32'h80FF_FF7F, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, "lb_slow", ns);
        check_w("lb_slow_stall_cycles", 32'(ns), 32'd3);
        check_b("lb_slow_resp_req", dmem_bus.req, 1'b0);
        check_b("lb_slow_resp_mwe", mem_we_mem, 1'b1);
        check_w("lb_slow_resp_data", mem_data_mem, 32'hFFFF_FF80);
        check_w("lb_slow_resp_rd", 32'(mem_addr_mem), 32'd9);
        check_b("lb_slow_resp_fault", mem_fault, 1'b0);
        $display("txn lb slow ack: stall cycles=%0d", ns);

        // Ack while idle must not start anything
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        dmem_bus.ack = 1'b1;
        @(negedge clk);
        check_b("idle_ack_req", dmem_bus.req, 1'b0);
        check_b("idle_ack_stall", stall, 1'b0);
        tick();
        @(negedge clk);
        check_b("idle_ack_req_next", dmem_bus.req, 1'b0);
        check_b("idle_ack_mwe_next", mem_we_mem, 1'b0);
        dmem_bus.ack = 1'b0;
        $display("txn stray ack in idle");

        // SH to 0x22, ack in the first REQ cycle
        tick();
        drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'h0000_ABCD, 5'd0, 1'b0);
        run_op(1, 32'h0, 32'h020, 1'b1, 1'b1, 4'b1100, 32'hABCD_ABCD, "sh", ns);
        check_w("sh_stall_cycles", 32'(ns), 32'd2);
        check_b("sh_resp_mwe", mem_we_mem, 1'b0);
        check_b("sh_resp_fault", mem_fault, 1'b0);
        check_b("sh_resp_req", dmem_bus.req, 1'b0);
        $display("txn sh: stall cycles=%0d", ns);

        // LW with no ack: timeout after 15 REQ cycles
        tick();
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd6, 1'b1);
        run_op(-1, 32'h0, 32'h300, 1'b0, 1'b0, 4'h0, 32'h0, "lw_to", ns);
        check_w("lw_to_stall_cycles", 32'(ns), 32'd16);
        check_b("lw_to_fault", mem_fault, 1'b1);
        check_b("lw_to_mwe", mem_we_mem, 1'b0);
        check_b("lw_to_req", dmem_bus.req, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        check_b("lw_to_fault_pulse_end", mem_fault, 1'b0);
        check_b("lw_to_idle_stall", stall, 1'b0);
        $display("txn lw timeout: stall cycles=%0d", ns);

        // Reset during the second REQ cycle abandons the access
        tick();
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd8, 1'b1);
        @(negedge clk);
        check_b("rst_mid_issue_req", dmem_bus.req, 1'b1);
        tick();
        @(negedge clk);
        check_b("rst_mid_req1_stall", stall, 1'b1);
        tick();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        check_b("rst_mid_req2_req", dmem_bus.req, 1'b1);
        tick();
        reset = 1'b0;
        dmem_bus.ack = 1'b1;
        @(negedge clk);
        check_b("rst_mid_after_req", dmem_bus.req, 1'b0);
        check_b("rst_mid_after_stall", stall, 1'b0);
        check_b("rst_mid_after_fault", mem_fault, 1'b0);
        check_b("rst_mid_after_mwe", mem_we_mem, 1'b0);
        tick();
        dmem_bus.ack = 1'b0;
        @(negedge clk);
        check_b("rst_mid_next_fault", mem_fault, 1'b0);
        check_b("rst_mid_next_mwe", mem_we_mem, 1'b0);
        check_b("rst_mid_next_req", dmem_bus.req, 1'b0);
        $display("txn reset mid-request");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
